// File: rtl/isqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root unit.
// State encoding plus width/cycle arithmetic derived from the parameters.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int out_width(int in_w, int frac);
    return in_w / 2 + frac;
  endfunction

  function automatic int cycles(int ow, int steps);
    return ow / steps;
  endfunction

  function automatic bit cfg_ok(int in_w, int frac, int steps);
    return (in_w % 2 == 0) && (steps > 0) &&
           (out_width(in_w, frac) % steps == 0);
  endfunction

endpackage

// File: rtl/isqrt_digit_step.sv
// One restoring square-root digit: folds two radicand bits into rem,
// resolves one root bit.
module isqrt_digit_step #(
  parameter int OW = 16
) (
  input  logic [OW+1:0] rem_i,
  input  logic [OW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [OW+1:0] rem_o,
  output logic [OW-1:0] root_o
);

  logic [OW+1:0] r2;
  logic [OW+1:0] trial;
  logic          ge;
  logic          unused_hi;

  // rem < 2^OW and root < 2^(OW-1) before every step, so the
  // dropped top bits are always zero.
  assign unused_hi = ^{rem_i[OW+1:OW], root_i[OW-1]};

  assign r2     = {rem_i[OW-1:0], bits_i};
  assign trial  = {root_i, 2'b01};
  assign ge     = (r2 >= trial);
  assign rem_o  = ge ? (r2 - trial) : r2;
  assign root_o = {root_i[OW-2:0], ge};

endmodule

// File: rtl/isqrt_pipe_ctrl.sv
// Iterative integer/fixed-point square root, valid/ready on both sides,
// STEPS_PER_CYCLE digits per clock with optional round-to-nearest.
module isqrt_pipe_ctrl
  import isqrt_pkg::*;
#(
  parameter  int IN_WIDTH        = 32,
  parameter  int FRAC_BITS       = 0,
  parameter  int STEPS_PER_CYCLE = 1,
  parameter  int ROUND_NEAREST   = 0,
  parameter  int TAG_W           = 4,
  localparam int OUT_WIDTH       = out_width(IN_WIDTH, FRAC_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_root,
  output logic [OUT_WIDTH:0]   out_rem,
  output logic                 out_neg,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int OW  = OUT_WIDTH;
  localparam int S   = STEPS_PER_CYCLE;
  localparam int RW  = 2 * OW;
  localparam int CYC = cycles(OW, S);
  localparam int CW  = $clog2(CYC + 1);

  if (!cfg_ok(IN_WIDTH, FRAC_BITS, STEPS_PER_CYCLE)) begin : g_bad_cfg
    $error("isqrt_pipe_ctrl: IN_WIDTH odd or STEPS_PER_CYCLE bad");
  end

  state_e          state_q;
  logic [RW-1:0]   rad_q;
  logic [OW+1:0]   rem_q;
  logic [OW-1:0]   root_q;
  logic [CW-1:0]   cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic            out_valid_q;
  logic [OW-1:0]   out_root_q;
  logic [OW:0]     out_rem_q;
  logic            out_neg_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [OW+1:0] rem_c  [0:S];
  logic [OW-1:0] root_c [0:S];
  logic          rnd_up;
  logic [OW-1:0] root_d;
  logic          unused_rem;

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar g = 0; g < S; g++) begin : g_step
    isqrt_digit_step #(
      .OW(OW)
    ) u_step (
      .rem_i (rem_c[g]),
      .root_i(root_c[g]),
      .bits_i(rad_q[RW-1-2*g -: 2]),
      .rem_o (rem_c[g+1]),
      .root_o(root_c[g+1])
    );
  end

  // Final rem <= 2*root, so its top bit is always clear.
  assign unused_rem = rem_c[S][OW+1];

  assign rnd_up = (ROUND_NEAREST != 0) &&
                  (rem_c[S] > {2'b00, root_c[S]}) &&
                  !(&root_c[S]);
  assign root_d = root_c[S] + OW'(rnd_up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_neg_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            tag_q <= in_tag;
            if (in_data[IN_WIDTH-1]) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_neg_q   <= 1'b1;
              out_root_q  <= '0;
              out_rem_q   <= '0;
              out_tag_q   <= in_tag;
            end else begin
              state_q   <= RUN;
              rad_q     <= RW'(in_data) << (2 * FRAC_BITS);
              rem_q     <= '0;
              root_q    <= '0;
              cnt_q     <= CW'(CYC);
              out_neg_q <= 1'b0;
            end
          end
        end
        RUN: begin
          rad_q  <= rad_q << (2 * S);
          rem_q  <= rem_c[S];
          root_q <= root_c[S];
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_root_q  <= root_d;
            out_rem_q   <= rem_c[S][OW:0];
            out_tag_q   <= tag_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_neg   = out_neg_q;
  assign out_tag   = out_tag_q;

endmodule
